stack_alu_ctrl: RTL and testbench
=================================

Name: stack_alu_ctrl

Overview:
- Sequencer that owns an 8-bit operand stack and drives the team's `alu` datapath.
- Accepts stack-machine commands over a valid/ready handshake: push immediate, pop, ALU op, clear.
- For an ALU op it pops the operands, runs the `alu` and pushes the result. It returns one response per command.
- Sits between the instruction decoder and the `alu`. It is the only driver of `alu.sel`.

Parameters:
- DEPTH, 16, number of stack entries; power of two, at least 2.
- DW, 8, data width; fixed at 8 to match `alu`.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_kind  in  2  0=PUSH, 1=POP, 2=ALU, 3=CLEAR.
- cmd_sel  in  4  ALU select for ALU commands; ignored otherwise.
- cmd_imm  in  8  immediate for PUSH.
- rsp_valid  out  1  one-cycle pulse, no backpressure.
- rsp_data  out  8  pushed value, popped value or ALU result; 0 for CLEAR and for errors.
- rsp_err  out  1  qualifies rsp_valid: overflow, underflow or illegal select.
- depth  out  $clog2(DEPTH)+1  current entry count.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - At reset: state=IDLE, sp=0, depth=0, rsp_valid=0, rsp_data=0, rsp_err=0. Stack RAM is not cleared.
  - A reset mid-command aborts the command and produces no response.
  - cmd_ready=1 from the first cycle after rst deasserts.
- Handshake: accept on cmd_valid&cmd_ready. kind, sel and imm are latched at accept. cmd_ready=0 in every state except IDLE.
- ALU select codes: 0 add, 1 and, 2 or, 3 xor, 4 not, 5 neg, 6 shr, 7 sar, 8 shl, 9 pass.
  - Unary selects: 4, 5, 9.
  - Selects 10-15 are illegal.
- Operand convention: b = top of stack (TOS), a = entry below TOS. Unary ops use a = TOS.
- ALU semantics: the `alu` sees the result modulo 256, with no carry out. The shift amount is the full 8-bit b, so an amount ≥8 yields 0 for shr/shl and sign fill for sar.
- Error checks are made at accept; an error leaves sp unchanged and goes straight to RESP.
  - PUSH when depth==DEPTH: overflow.
  - POP or unary ALU when depth==0: underflow.
  - Binary ALU when depth<2: underflow.
  - ALU with select 10-15: illegal.
- State machine:
  - IDLE: on accept, route as follows:
    - error → RESP.
    - PUSH → WB, with res=imm.
    - POP or unary → RD_A.
    - binary → RD_B.
    - CLEAR → RESP, with sp←0.
  - RD_B: b←mem[sp-1], sp←sp-1 → RD_A.
  - RD_A: a←mem[sp-1], sp←sp-1. POP → RESP with res=a; otherwise → EXEC.
  - EXEC: drive alu.sel=sel; res←alu.q → WB.
  - WB: mem[sp]←res, sp←sp+1 → RESP.
  - RESP: rsp_valid=1 for exactly one cycle → IDLE.
- `alu.sel` is held at 9 (pass) outside EXEC, so the `alu` never sees an undefined select.
- Latency, in cycles from the accept edge to rsp_valid high:
  - error or CLEAR: 1
  - PUSH: 2
  - POP: 2
  - unary: 4
  - binary: 5
- Throughput: the next accept is possible in the cycle after RESP.
- rsp_data and rsp_err are registered and hold their value until the next RESP.
- depth tracks sp combinationally and is visible mid-command: it drops in RD states and rises in WB.
- Stack pointer range: sp never wraps. The accept-time checks guarantee 0≤sp≤DEPTH.

Decomposition:
- Package stack_alu_pkg:
  - cmd_kind constants: KIND_PUSH, KIND_POP, KIND_ALU, KIND_CLEAR.
  - ALU select constants: SEL_ADD … SEL_PASS.
  - is_unary(sel) and is_legal(sel) functions.
  - State enum: IDLE, RD_B, RD_A, EXEC, WB, RESP.
- Sub-module: instantiate the existing `alu` unchanged; a, b and sel are driven from registers.
- The stack RAM is inline: a DEPTH×8 register array with one write port and one read port.

Test Plan:
- Reset, then PUSH 0x05, then PUSH 0x03, then ALU sel=0 → responses 05 and 03 with err=0, then add result 0x08 with err=0 exactly 5 cycles after its accept; depth ends at 1.
- Stack holds 0x80, apply ALU sel=7 (sar) with b=0x09 pushed above → result 0xFF; repeat with shr → 0x00; with shl of 0x01 by 0x07 → 0x80.
- Unary sel=5 (neg) on TOS 0x01 → 0xFF; 4-cycle latency; depth unchanged.
- Underflow and overflow:
  - POP at depth 0 → rsp_err=1 after 1 cycle, depth stays 0.
  - Binary ALU at depth 1 → err=1, depth stays 1.
  - 17th PUSH with DEPTH=16 → err=1, depth stays 16.
- Illegal ALU sel=12 at depth 2 → err=1 and data 0; stack contents are intact, confirmed by a following POP returning the original TOS.
- rst asserted during EXEC of a binary op → no rsp_valid; depth=0 and cmd_ready=1 the cycle after release; a following POP errors; CLEAR at depth 3 → depth=0, rsp_valid after 1 cycle.

Source files
------------

// File: rtl/stack_alu_pkg.sv
// Shared encodings for the stack sequencer: command kinds, ALU selects, FSM states.
package stack_alu_pkg;

    localparam logic [1:0] KIND_PUSH  = 2'd0;
    localparam logic [1:0] KIND_POP   = 2'd1;
    localparam logic [1:0] KIND_ALU   = 2'd2;
    localparam logic [1:0] KIND_CLEAR = 2'd3;

    localparam logic [3:0] SEL_ADD  = 4'd0;
    localparam logic [3:0] SEL_AND  = 4'd1;
    localparam logic [3:0] SEL_OR   = 4'd2;
    localparam logic [3:0] SEL_XOR  = 4'd3;
    localparam logic [3:0] SEL_NOT  = 4'd4;
    localparam logic [3:0] SEL_NEG  = 4'd5;
    localparam logic [3:0] SEL_SHR  = 4'd6;
    localparam logic [3:0] SEL_SAR  = 4'd7;
    localparam logic [3:0] SEL_SHL  = 4'd8;
    localparam logic [3:0] SEL_PASS = 4'd9;

    typedef enum logic [2:0] {
        IDLE,
        RD_B,
        RD_A,
        EXEC,
        WB,
        RESP
    } state_t;

    function automatic logic is_unary(input logic [3:0] sel);
        return (sel == SEL_NOT) || (sel == SEL_NEG) || (sel == SEL_PASS);
    endfunction

    function automatic logic is_legal(input logic [3:0] sel);
        return sel <= SEL_PASS;
    endfunction

endpackage

// File: rtl/stack_alu_ctrl_alu.sv
// Shared 8-bit combinational ALU datapath. Results wrap modulo 256; shifts use the full 8-bit b.
module alu (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] sel,
    output logic [7:0] q
);

    always_comb begin
        q = '0;
        case (sel)
            4'd0:    q = a + b;
            4'd1:    q = a & b;
            4'd2:    q = a | b;
            4'd3:    q = a ^ b;
            4'd4:    q = ~a;
            4'd5:    q = -a;
            4'd6:    q = a >> b;
            4'd7:    q = $unsigned($signed(a) >>> b);
            4'd8:    q = a << b;
            4'd9:    q = a;
            default: q = '0;
        endcase
    end

endmodule

// File: rtl/stack_alu_ctrl.sv
// Stack-machine sequencer: owns the operand stack, pops operands into the alu, pushes results,
// and returns one response per command.
module stack_alu_ctrl
    import stack_alu_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_kind,
    input  logic [3:0]               cmd_sel,
    input  logic [DW-1:0]            cmd_imm,
    output logic                     rsp_valid,
    output logic [DW-1:0]            rsp_data,
    output logic                     rsp_err,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);

    state_t          r_state, w_next;
    logic [AW:0]     r_sp;
    logic [DW-1:0]   r_mem [DEPTH];
    logic [1:0]      r_kind;
    logic [3:0]      r_sel, r_alu_sel;
    logic [DW-1:0]   r_a, r_b, r_res, r_rsp_data;
    logic            r_rsp_err;
    logic            w_accept, w_err;
    logic [AW-1:0]   w_rd_idx;
    logic [DW-1:0]   w_tos, w_alu_q;

    assign w_accept = cmd_valid & cmd_ready;
    // sp == DEPTH aliases to index 0, so minus one still lands on the top entry
    assign w_rd_idx = r_sp[AW-1:0] - AW'(1);
    assign w_tos    = r_mem[w_rd_idx];
    assign depth    = r_sp;
    assign rsp_data = r_rsp_data;
    assign rsp_err  = r_rsp_err;

    always_comb begin
        w_err = 1'b0;
        case (cmd_kind)
            KIND_PUSH: w_err = (r_sp == FULL);
            KIND_POP:  w_err = (r_sp == '0);
            KIND_ALU: begin
                if (!is_legal(cmd_sel))     w_err = 1'b1;
                else if (is_unary(cmd_sel)) w_err = (r_sp == '0);
                else                        w_err = (r_sp < TWO);
            end
            default:   w_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_err) w_next = RESP;
                    else begin
                        case (cmd_kind)
                            KIND_PUSH: w_next = WB;
                            KIND_POP:  w_next = RD_A;
                            KIND_ALU:  w_next = is_unary(cmd_sel) ? RD_A : RD_B;
                            default:   w_next = RESP;
                        endcase
                    end
                end
            end
            RD_B:    w_next = RD_A;
            RD_A:    w_next = (r_kind == KIND_POP) ? RESP : EXEC;
            EXEC:    w_next = WB;
            WB:      w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == IDLE);
        rsp_valid = (r_state == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp       <= '0;
            r_kind     <= KIND_PUSH;
            r_sel      <= SEL_PASS;
            r_alu_sel  <= SEL_PASS;
            r_a        <= '0;
            r_b        <= '0;
            r_res      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            // select is registered so the alu sees pass everywhere but EXEC
            r_alu_sel <= (w_next == EXEC) ? r_sel : SEL_PASS;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_kind <= cmd_kind;
                        r_sel  <= cmd_sel;
                        r_res  <= cmd_imm;
                        if (w_err) begin
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b1;
                        end else if (cmd_kind == KIND_CLEAR) begin
                            r_sp       <= '0;
                            r_rsp_data <= '0;
                            r_rsp_err  <= 1'b0;
                        end
                    end
                end
                RD_B: begin
                    r_b  <= w_tos;
                    r_sp <= r_sp - ONE;
                end
                RD_A: begin
                    r_a  <= w_tos;
                    r_sp <= r_sp - ONE;
                    if (r_kind == KIND_POP) begin
                        r_rsp_data <= w_tos;
                        r_rsp_err  <= 1'b0;
                    end
                end
                EXEC: r_res <= w_alu_q;
                WB: begin
                    r_sp       <= r_sp + ONE;
                    r_rsp_data <= r_res;
                    r_rsp_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && r_state == WB) r_mem[r_sp[AW-1:0]] <= r_res;
    end

    alu u_alu (
        .a   (r_a),
        .b   (r_b),
        .sel (r_alu_sel),
        .q   (w_alu_q)
    );

endmodule

// File: tb/tb_stack_alu_ctrl.sv
// Randomized bench for stack_alu_ctrl against a queue-based stack-machine model.
module tb_stack_alu_ctrl;

    localparam int DEPTH = 16;

    logic       clk, rst;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_kind;
    logic [3:0] cmd_sel;
    logic [7:0] cmd_imm;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [4:0] depth;

    int n_cmp = 0;
    int n_bad = 0;
    byte unsigned stk[$];

    stack_alu_ctrl #(.DEPTH(DEPTH), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_kind  (cmd_kind),
        .cmd_sel   (cmd_sel),
        .cmd_imm   (cmd_imm),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .depth     (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic int alu_ref(input int sel, input int a, input int b);
        int sa, p;
        case (sel)
            0: return (a + b) % 256;
            1: return a & b;
            2: return a | b;
            3: return a ^ b;
            4: return 255 - a;
            5: return (256 - a) % 256;
            6: return (b >= 8) ? 0 : a / (1 << b);
            7: begin
                sa = (a >= 128) ? a - 256 : a;
                if (b >= 8) return (sa < 0) ? 255 : 0;
                p = 1 << b;
                sa = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
                return sa & 255;
            end
            8: return (b >= 8) ? 0 : (a * (1 << b)) % 256;
            9: return a;
            default: return 0;
        endcase
    endfunction

    // Applies one command to the model stack and predicts the response.
    task automatic model(input int k, input int s, input int imm,
                         output int d, output int e, output int lat);
        int a, b;
        d = 0; e = 0; lat = 1;
        case (k)
            0: if (stk.size() == DEPTH) e = 1;
               else begin stk.push_back(8'(imm)); d = imm; lat = 2; end
            1: if (stk.size() == 0) e = 1;
               else begin d = stk.pop_back(); lat = 2; end
            2: begin
                if (s > 9) e = 1;
                else if (s == 4 || s == 5 || s == 9) begin
                    if (stk.size() < 1) e = 1;
                    else begin
                        a = stk.pop_back(); d = alu_ref(s, a, 0);
                        stk.push_back(8'(d)); lat = 4;
                    end
                end else begin
                    if (stk.size() < 2) e = 1;
                    else begin
                        b = stk.pop_back(); a = stk.pop_back(); d = alu_ref(s, a, b);
                        stk.push_back(8'(d)); lat = 5;
                    end
                end
            end
            default: stk.delete();
        endcase
    endtask

    task automatic run_cmd(input int k, input int s, input int imm);
        int d, e, lat, got_lat, guard;
        model(k, s, imm, d, e, lat);
        guard = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        chk("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_kind  = 2'(k);
        cmd_sel   = 4'(s);
        cmd_imm   = 8'(imm);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_kind  = 2'($urandom);
        cmd_sel   = 4'($urandom);
        cmd_imm   = 8'($urandom);
        got_lat = 1;
        while (!rsp_valid && got_lat < 12) begin @(negedge clk); got_lat++; end
        chk($sformatf("latency k%0d s%0d", k, s), got_lat, lat);
        chk($sformatf("data k%0d s%0d", k, s), rsp_data, d);
        chk($sformatf("err k%0d s%0d", k, s), rsp_err, e);
        chk("depth", depth, stk.size());
        @(negedge clk);
        chk("rsp_pulse", rsp_valid, 0);
        chk("data_hold", rsp_data, d);
    endtask

    initial begin
        int k, s, imm, r;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_kind = '0;
        cmd_sel = '0;
        cmd_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", rsp_valid, 0);
        chk("rst_data", rsp_data, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_depth", depth, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", cmd_ready, 1);

        run_cmd(0, 0, 8'h05);
        run_cmd(0, 0, 8'h03);
        run_cmd(2, 0, 0);

        run_cmd(3, 0, 0);
        run_cmd(0, 0, 8'h80); run_cmd(0, 0, 8'h09); run_cmd(2, 7, 0);
        run_cmd(0, 0, 8'h80); run_cmd(0, 0, 8'h09); run_cmd(2, 6, 0);
        run_cmd(0, 0, 8'h01); run_cmd(0, 0, 8'h07); run_cmd(2, 8, 0);

        run_cmd(3, 0, 0);
        run_cmd(0, 0, 8'h01); run_cmd(2, 5, 0);

        run_cmd(3, 0, 0);
        run_cmd(1, 0, 0);
        run_cmd(0, 0, 8'h01); run_cmd(2, 0, 0);

        run_cmd(3, 0, 0);
        for (int i = 0; i < DEPTH + 1; i++) run_cmd(0, 0, i + 1);

        run_cmd(3, 0, 0);
        run_cmd(0, 0, 8'h11); run_cmd(0, 0, 8'h22);
        run_cmd(2, 12, 0);
        run_cmd(1, 0, 0);

        // reset while a binary op sits in EXEC
        run_cmd(3, 0, 0);
        run_cmd(0, 0, 8'h03); run_cmd(0, 0, 8'h04);
        cmd_valid = 1'b1; cmd_kind = 2'd2; cmd_sel = 4'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_depth", depth, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid0", rsp_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid1", rsp_valid, 0);
        chk("abort_depth", depth, 0);
        chk("abort_ready", cmd_ready, 1);
        stk.delete();
        run_cmd(1, 0, 0);
        run_cmd(0, 0, 1); run_cmd(0, 0, 2); run_cmd(0, 0, 3);
        run_cmd(3, 0, 0);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       k = 0;
            else if (r < 11) k = 1;
            else if (r < 19) k = 2;
            else             k = 3;
            s = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 9) : $urandom_range(10, 15);
            imm = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 9) : $urandom_range(0, 255);
            run_cmd(k, s, imm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
